// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// Defines the FSM state encoding, the default round count and the rndNo width.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } aes_state_t;

  localparam int NR_DEFAULT = 10;
  localparam int RND_W      = 4;

endpackage

// File: rtl/aes_if.sv
// Request handshake plus the control lines the controller drives into the AES core.
// The master modport is the requester side; the slave modport is the controller side.
interface aes_if;
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             accept;
  logic             KS_Select;
  logic [RND_W-1:0] rndNo;
  logic             busy;
  logic             done;

  modport master (
    output in_valid,
    input  in_ready, accept, KS_Select, rndNo, busy, done
  );

  modport slave (
    input  in_valid,
    output in_ready, accept, KS_Select, rndNo, busy, done
  );

endinterface

// File: rtl/aes_cycle_counter.sv
// Modulo-MODULUS counter with enable and synchronous clear.
// Raises wrap combinationally while enabled on the last count value.
module aes_cycle_counter #(
  parameter int MODULUS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int WIDTH = $clog2(MODULUS + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count;

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_controller.sv
// Sequences one AES block through load, NR rounds and the core drain period.
// Moore FSM: every output is decoded from the state register and the round counter.
module aes_controller
  import aes_pkg::*;
#(
  parameter int NR           = NR_DEFAULT,
  parameter int ROUND_CYCLES = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  aes_if.slave bus
);

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NR);
  // A zero-length drain never enables its counter, so its modulus just needs to be legal.
  localparam int DRAIN_MOD = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;

  aes_state_t       state;
  aes_state_t       state_next;
  logic [RND_W-1:0] round_cnt;
  logic             in_round;
  logic             in_drain;
  logic             cyc_wrap;
  logic             drain_wrap;

  assign in_round = (state == ROUND);
  assign in_drain = (state == DRAIN);

  aes_cycle_counter #(.MODULUS(ROUND_CYCLES)) u_round_cycles (
    .clk  (clk),
    .rst  (rst),
    .en   (in_round),
    .clr  (!in_round),
    .wrap (cyc_wrap)
  );

  aes_cycle_counter #(.MODULUS(DRAIN_MOD)) u_drain_cycles (
    .clk  (clk),
    .rst  (rst),
    .en   (in_drain),
    .clr  (!in_drain),
    .wrap (drain_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = bus.in_valid ? LOAD : IDLE;
      LOAD:    state_next = ROUND;
      ROUND: begin
        state_next = ROUND;
        if (cyc_wrap && (round_cnt == LAST_ROUND)) begin
          state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end
      end
      DRAIN:   state_next = drain_wrap ? DONE : DRAIN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Round number saturates at NR so it holds through drain and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= '0;
    end else begin
      case (state)
        IDLE:  round_cnt <= '0;
        LOAD:  round_cnt <= RND_W'(1);
        ROUND: begin
          if (cyc_wrap && (round_cnt != LAST_ROUND)) begin
            round_cnt <= round_cnt + 1'b1;
          end
        end
        default: round_cnt <= round_cnt;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.accept    = 1'b0;
    bus.KS_Select = 1'b0;
    bus.rndNo     = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      LOAD: begin
        bus.accept    = 1'b1;
        bus.KS_Select = 1'b1;
        bus.busy      = 1'b1;
      end
      ROUND, DRAIN: begin
        bus.rndNo = round_cnt;
        bus.busy  = 1'b1;
      end
      DONE: begin
        bus.rndNo = round_cnt;
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_controller.sv
// Directed bench for aes_controller: default build plus an NR=14/ROUND_CYCLES=1/DRAIN_CYCLES=0 build.
// Expected values come from the cycle-by-cycle timeline of a block measured from its handshake cycle.
module tb_aes_controller;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  aes_if bus_a();
  aes_if bus_b();

  aes_controller dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  aes_controller #(.NR(14), .ROUND_CYCLES(1), .DRAIN_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    if (observed !== 32'(expected)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic valid_a, input logic valid_b);
    rst            = rst_v;
    bus_a.in_valid = valid_a;
    bus_b.in_valid = valid_b;
    @(posedge clk);
    #1;
  endtask

  // Cycle c counts from the handshake cycle (c=0); anything after the done cycle is idle.
  task automatic checkBus(input string tag, input int c, input int nr, input int rc, input int dc,
                          input logic rdy, input logic acc, input logic ks, input logic [3:0] rnd,
                          input logic bsy, input logic dn);
    int lat     = 2 + nr * rc + dc;
    int rnd_end = 2 + nr * rc;
    int e_rdy = 0, e_acc = 0, e_rnd = 0, e_bsy = 0, e_dn = 0;
    if (c == 0 || c > lat) begin
      e_rdy = 1;
    end else if (c == 1) begin
      e_acc = 1;
      e_bsy = 1;
    end else if (c < rnd_end) begin
      e_rnd = (c - 2) / rc + 1;
      e_bsy = 1;
    end else begin
      e_rnd = nr;
      e_bsy = 1;
      e_dn  = (c == lat) ? 1 : 0;
    end
    checkOutput($sformatf("%s.c%0d.in_ready", tag, c), 32'(rdy), e_rdy);
    checkOutput($sformatf("%s.c%0d.accept", tag, c), 32'(acc), e_acc);
    checkOutput($sformatf("%s.c%0d.KS_Select", tag, c), 32'(ks), e_acc);
    checkOutput($sformatf("%s.c%0d.rndNo", tag, c), 32'(rnd), e_rnd);
    checkOutput($sformatf("%s.c%0d.busy", tag, c), 32'(bsy), e_bsy);
    checkOutput($sformatf("%s.c%0d.done", tag, c), 32'(dn), e_dn);
  endtask

  task automatic checkA(input string tag, input int c);
    checkBus(tag, c, 10, 5, 2, bus_a.in_ready, bus_a.accept, bus_a.KS_Select,
             bus_a.rndNo, bus_a.busy, bus_a.done);
  endtask

  task automatic checkB(input string tag, input int c);
    checkBus(tag, c, 14, 1, 0, bus_b.in_ready, bus_b.accept, bus_b.KS_Select,
             bus_b.rndNo, bus_b.busy, bus_b.done);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int done_cnt;
    int acc_cnt;
    int done_at;
    int max_rnd;

    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkA("reset_a", 0);
    checkB("reset_b", 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkA("reset_prio_a", 0);
    checkB("reset_prio_b", 0);

    $display("[TB] single block");
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 56; c++) begin
      checkA("single", c);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] held in_valid");
    done_cnt = 0;
    acc_cnt  = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 110; c++) begin
      checkA("held", c % 55);
      if (bus_a.done === 1'b1) done_cnt++;
      if (bus_a.accept === 1'b1) acc_cnt++;
      applyStimulus(1'b0, (c < 110) ? 1'b1 : 1'b0, 1'b0);
    end
    checkOutput("held.done_count", 32'(done_cnt), 2);
    checkOutput("held.accept_count", 32'(acc_cnt), 2);
    checkA("held_after", 111);

    $display("[TB] reset mid-encryption");
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      checkA("abort", c);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkA("abort", 20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkA("abort_c21_idle", 0);
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (bus_a.done === 1'b1) done_cnt++;
    end
    checkOutput("abort.done_count", 32'(done_cnt), 0);
    checkOutput("abort.busy_after", 32'(bus_a.busy), 0);

    $display("[TB] requests while busy and during done");
    done_cnt = 0;
    acc_cnt  = 0;
    done_at  = -1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 120; c++) begin
      checkA("ignore", c);
      if (bus_a.done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (bus_a.accept === 1'b1) acc_cnt++;
      applyStimulus(1'b0, (c == 10 || c == 54) ? 1'b1 : 1'b0, 1'b0);
    end
    checkOutput("ignore.done_count", 32'(done_cnt), 1);
    checkOutput("ignore.done_cycle", 32'(done_at), 54);
    checkOutput("ignore.accept_count", 32'(acc_cnt), 1);

    $display("[TB] NR=14 ROUND_CYCLES=1 DRAIN_CYCLES=0");
    max_rnd = 0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      checkB("sweep", c);
      if (int'(bus_b.rndNo) > max_rnd) max_rnd = int'(bus_b.rndNo);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("sweep.max_rndNo", 32'(max_rnd), 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
